// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size codes, FSM states and the
// registered request record.
package lsu_pkg;
   localparam int ADDR_W_DEF = 11;
   localparam int DEPTH_DEF  = 512;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   typedef enum logic [2:0] {IDLE, READ, DATA, MERGE, WRITE, DONE} state_t;

   // Only what the later states need: lane offset and the low half of store data.
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sign;
      logic [1:0]  lane;
      logic [15:0] wdata;
   } req_t;
endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [15:0] wdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] ldata,
   output logic [31:0] merged
);
   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = word[7:0];
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];

      case (size)
         SZ_B:    ldata = {{24{sign & b[7]}}, b};
         SZ_H:    ldata = {{16{sign & h[15]}}, h};
         default: ldata = word;
      endcase

      // Untouched bytes pass through bit-exact from the old word.
      merged = word;
      case (size)
         SZ_B: merged[{lane, 3'b000} +: 8] = wdata[7:0];
         SZ_H: begin
            if (lane[1]) merged[31:16] = wdata;
            else         merged[15:0]  = wdata;
         end
         default: merged = word;
      endcase
   end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, RMW for sub-word stores against a
// byte-enable-less synchronous RAM; all outputs are registered.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_sign,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;

   state_t      state;
   req_t        rq;
   logic        req_err;
   logic        bad_align;
   logic        oor;
   logic [31:0] ld_val;
   logic [31:0] st_word;

   assign req_ready = (state == IDLE);

   assign bad_align = (req_size == SZ_H && req_addr[0]) ||
                      (req_size == SZ_W && req_addr[1:0] != 2'b00);
   // No aliasing: anything past the RAM is rejected rather than wrapped.
   assign oor       = (|req_addr[31:ADDR_W]) || (req_addr >= LIMIT);
   assign req_err   = bad_align || oor || (req_size == SZ_X);

   lsu_lane u_lane (
      .word   (mem_rdata),
      .wdata  (rq.wdata),
      .lane   (rq.lane),
      .size   (rq.size),
      .sign   (rq.sign),
      .ldata  (ld_val),
      .merged (st_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rq         <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               rq       <= '{we: req_we, size: req_size, sign: req_sign,
                             lane: req_addr[1:0], wdata: req_wdata[15:0]};
               mem_addr <= req_addr[ADDR_W-1:2];
               if (req_err) begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else if (!req_we || req_size != SZ_W) begin
                  state  <= READ;
                  mem_en <= 1'b1;
                  mem_we <= 1'b0;
               end else begin
                  state     <= WRITE;
                  mem_en    <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_wdata <= req_wdata;
               end
            end
            READ: begin
               mem_en <= 1'b0;
               state  <= rq.we ? MERGE : DATA;
            end
            DATA: begin
               resp_rdata <= ld_val;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               state      <= DONE;
            end
            MERGE: begin
               mem_wdata <= st_word;
               mem_en    <= 1'b1;
               mem_we    <= 1'b1;
               state     <= WRITE;
            end
            WRITE: begin
               mem_en     <= 1'b0;
               mem_we     <= 1'b0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               state      <= DONE;
            end
            DONE: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the rv32i datapath and a single-port synchronous data RAM. It accepts one byte, halfword or word request at a time over a valid/ready handshake. Loads are extracted little-endian and sign- or zero-extended. Sub-word stores are done as read-modify-write, because the RAM has no byte enables; misaligned or out-of-range accesses complete with an error and never touch memory.

## Interface
- ADDR_W, 11: byte-address width of the data RAM; 2 kB.
- DEPTH, 512: RAM words; word index is addr[ADDR_W-1:2].
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_we  in  1  1 store, 0 load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_sign  in  1  loads only: 1 sign-extend, 0 zero-extend.
- req_addr  in  32  byte address (ALU output).
- req_wdata  in  32  store data; the low byte or half is used for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; set on misalignment, out-of-range address or illegal size.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write; only meaningful with mem_en.
- mem_addr  out  ADDR_W-2  word index.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after a read strobe.

## Operation
- Request fields are registered on acceptance; the outputs derive from the registered copy only.
- Error check at acceptance (error takes IDLE -> DONE):
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - size=11;
  - any bit of addr[31:ADDR_W] set.
- State sequences:
  - IDLE -> READ -> DATA -> DONE: load.
  - IDLE -> WRITE -> DONE: word store.
  - IDLE -> READ -> MERGE -> WRITE -> DONE: byte or half store.
  - IDLE -> DONE: error.
- READ: mem_en=1, mem_we=0.
- DATA: extract the lane (byte at addr[1:0], half at addr[1]), extend, and register into resp_rdata.
- MERGE: register the old word with the new byte or half substituted at its lane; all other bytes are kept bit-exact.
- WRITE: mem_en=1, mem_we=1, mem_wdata = merged word (or req_wdata for a word store).
- DONE: resp_valid=1; resp_err as computed; then go to IDLE.
- In DONE, resp_rdata holds the loaded value for a load and 0 otherwise. It holds its last value outside DONE, and consumers sample it only with resp_valid.
- Requests presented while req_ready=0 are ignored; the requester holds them.

## Timing
- Request accepted at edge T. resp_valid is high in cycle:
  - T+1 for an error;
  - T+2 for a word store;
  - T+3 for a load;
  - T+4 for a sub-word store.
- Back-to-back: req_ready rises the cycle after DONE. Peak throughput is one word store every 3 cycles.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: mem_en and mem_we drop immediately (asynchronous). An in-flight request is discarded with no response. A write is only committed if its RAM edge preceded reset.
- Address wrap: none. Addresses ≥ 2^ADDR_W produce an error rather than aliasing.

## Structure
- Package lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), the state enum (IDLE, READ, DATA, MERGE, WRITE, DONE), and ADDR_W/DEPTH defaults.
- Sub-module lsu_lane: purely combinational.
  - Load path: extract and extend from (word, lane, size, sign).
  - Store path: merge from (old word, new data, lane, size).
- The FSM and registers stay in lsu.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x010 -> mem write to word 4 at T+1, resp at T+2; load word 0x010 -> resp_rdata=0xDEADBEEF at T+3, err=0.
- Signed and unsigned byte loads: with word 4 = 0xDEADBEEF:
  - lb 0x013 -> 0xFFFFFFDE;
  - lbu 0x013 -> 0x000000DE;
  - lh 0x010 -> 0xFFFFBEEF;
  - lhu 0x012 -> 0x0000DEAD.
- Sub-word store RMW: with word 4 = 0xDEADBEEF:
  - sb 0x55 at 0x011 -> RAM word 0xDEAD55EF, resp at T+4;
  - then sh 0x1234 at 0x012 -> 0x123455EF.
- Errors, each giving resp_err=1 at T+1 with mem_en never asserted:
  - lh at 0x001;
  - sw at 0x002;
  - lw at 0x800;
  - size=11.
- Handshake: hold req_valid high continuously with 3 queued loads -> exactly 3 acceptances, each only in IDLE, responses in order, no duplicated acceptance.
- Reset during a sub-word store in MERGE -> outputs return to reset values asynchronously, no RAM write occurs, resp_valid stays 0, and the next request completes normally.
